// File: rtl/transfusion_match_scheduler_if.sv
// Request/donation/response bundle between the requester front-ends and the
// transfusion match scheduler.
interface transfusion_match_scheduler_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   reqValid;
  logic [3*N_REQ-1:0] reqType;
  logic               donValid;
  logic [2:0]         donType;
  logic               respValid;
  logic [2:0]         respId;
  logic               respOk;
  logic [2:0]         respDonorType;
  logic [7:0]         stockEmpty;
  logic               donOverflow;
  logic               busy;
  logic [1:0]         dbgState;

  // Handshake: a requester holds reqValid (and may change reqType freely) until
  // respValid is high for one cycle with respId equal to its index.
  modport master (
    output reqValid, reqType, donValid, donType,
    input  respValid, respId, respOk, respDonorType, stockEmpty, donOverflow,
           busy, dbgState
  );

  modport slave (
    input  reqValid, reqType, donValid, donType,
    output respValid, respId, respOk, respDonorType, stockEmpty, donOverflow,
           busy, dbgState
  );
endinterface

// File: rtl/transfusion_match_scheduler.sv
// Round-robin shared compatibility scan over an 8-type donor inventory:
// one winner is scanned one candidate type per cycle, then granted or rejected.
module transfusion_match_scheduler #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 6
) (
  input logic                          clk,
  input logic                          rst_n,
  transfusion_match_scheduler_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_RESP = 2'd2} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d, id_q, id_d, type_q, type_d;
  logic [2:0]       k_q, k_d, dtype_q, dtype_d;
  logic             ok_q, ok_d, ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];

  logic [2:0] cand, win, win_hi, win_any, win_type;
  logic [3:0] hi_code;
  logic       found_hi, found_any, cand_hit;

  function automatic logic compat(input logic [2:0] d, input logic [2:0] r);
    return ((d[2:1] & ~r[2:1]) == 2'b00) && (!d[0] || r[0]);
  endfunction

  // Candidate 0 is the exact type; k>=1 walks 7..0 downward, skipping the exact type.
  always_comb begin
    hi_code = 4'd8 - {1'b0, k_q};
    if (k_q == 3'd0)                   cand = type_q;
    else if (hi_code > {1'b0, type_q}) cand = hi_code[2:0];
    else                               cand = hi_code[2:0] - 3'd1;
    cand_hit = (state_q == S_SCAN) && compat(cand, type_q) && (cnt_q[cand] != '0);
  end

  // First pending requester at or above the pointer, else the lowest one (wrap).
  always_comb begin
    found_hi  = 1'b0;
    found_any = 1'b0;
    win_hi    = 3'd0;
    win_any   = 3'd0;
    win_type  = 3'd0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found_hi && bus.reqValid[i] && (3'(i) >= ptr_q)) begin
        found_hi = 1'b1;
        win_hi   = 3'(i);
      end
      if (!found_any && bus.reqValid[i]) begin
        found_any = 1'b1;
        win_any   = 3'(i);
      end
    end
    win = found_hi ? win_hi : win_any;
    for (int i = 0; i < N_REQ; i++) begin
      if (3'(i) == win) win_type = bus.reqType[3*i +: 3];
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    type_d  = type_q;
    k_d     = k_q;
    ok_d    = ok_q;
    dtype_d = dtype_q;
    case (state_q)
      S_IDLE: begin
        if (found_any) begin
          id_d    = win;
          type_d  = win_type;
          k_d     = 3'd0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (cand_hit) begin
          dtype_d = cand;
          ok_d    = 1'b1;
          state_d = S_RESP;
        end else if (k_q == 3'd7) begin
          dtype_d = 3'd0;
          ok_d    = 1'b0;
          state_d = S_RESP;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      S_RESP: begin
        ptr_d   = (id_q == 3'(N_REQ - 1)) ? 3'd0 : id_q + 3'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A donation landing on the type being allocated this cycle cancels out.
  always_comb begin
    ovf_d = bus.donValid && (cnt_q[bus.donType] == CNT_MAX) &&
            !(cand_hit && (cand == bus.donType));
    for (int t = 0; t < 8; t++) begin
      cnt_d[t] = cnt_q[t];
      if (bus.donValid && (bus.donType == 3'(t))) begin
        if (!(cand_hit && (cand == 3'(t))) && (cnt_q[t] != CNT_MAX))
          cnt_d[t] = cnt_q[t] + 1'b1;
      end else if (cand_hit && (cand == 3'(t))) begin
        cnt_d[t] = cnt_q[t] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= 3'd0;
      id_q    <= 3'd0;
      type_q  <= 3'd0;
      k_q     <= 3'd0;
      ok_q    <= 1'b0;
      dtype_q <= 3'd0;
      ovf_q   <= 1'b0;
      for (int t = 0; t < 8; t++) cnt_q[t] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      type_q  <= type_d;
      k_q     <= k_d;
      ok_q    <= ok_d;
      dtype_q <= dtype_d;
      ovf_q   <= ovf_d;
      for (int t = 0; t < 8; t++) cnt_q[t] <= cnt_d[t];
    end
  end

  always_comb begin
    for (int t = 0; t < 8; t++) bus.stockEmpty[t] = (cnt_q[t] == '0);
  end

  assign bus.respValid     = (state_q == S_RESP);
  assign bus.respId        = bus.respValid ? id_q : 3'd0;
  assign bus.respOk        = bus.respValid && ok_q;
  assign bus.respDonorType = bus.respValid ? dtype_q : 3'd0;
  assign bus.donOverflow   = ovf_q;
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.dbgState      = state_q;
endmodule
